// File: rtl/edge_cache.sv
// ----------------------------------------------------------------------
// edge_cache: single-row adjacency-matrix cache with pipelined row fetch.
// Rev 1.0
// ----------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module edge_cache #(
   parameter int MAX_NODES   = 16,
   parameter int INDEX_WIDTH = 8,
   parameter int VALUE_WIDTH = 16,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic [ADDR_WIDTH-1:0]  base_address,
   input  logic [INDEX_WIDTH-1:0] number_of_nodes,
   input  logic                   ec_query,
   input  logic [INDEX_WIDTH-1:0] ec_from_node,
   input  logic [INDEX_WIDTH-1:0] ec_to_node,
   output logic                   ec_ready,
   output logic [VALUE_WIDTH-1:0] ec_edge_value,
   output logic                   mem_read,
   output logic [ADDR_WIDTH-1:0]  mem_address,
   input  logic                   mem_waitrequest,
   input  logic [VALUE_WIDTH-1:0] mem_readdata,
   input  logic                   mem_readdatavalid
);

   localparam int                 BUF_AW      = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
   localparam int                 CNT_W       = INDEX_WIDTH + 1;
   localparam logic [CNT_W-1:0]   c_max_nodes = CNT_W'(MAX_NODES);
   localparam logic [VALUE_WIDTH-1:0] c_no_edge = '1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t                  state_q;
   logic                    row_valid_q;
   logic                    flush_pend_q;
   logic [INDEX_WIDTH-1:0]  row_tag_q;
   logic [CNT_W-1:0]        issue_q;
   logic [CNT_W-1:0]        recv_q;
   logic [VALUE_WIDTH-1:0]  row_buf_q [MAX_NODES];
   logic                    mem_read_q;
   logic [ADDR_WIDTH-1:0]   mem_address_q;

   logic [CNT_W-1:0]        w_nodes;
   logic [CNT_W-1:0]        w_to;
   logic                    w_hit;
   logic                    w_ready;
   logic                    w_in_range;
   logic                    w_accept;
   logic [CNT_W-1:0]        w_issue_d;
   logic [CNT_W-1:0]        w_recv_d;
   logic                    w_done;
   logic [ADDR_WIDTH-1:0]   w_row_base;
   logic [ADDR_WIDTH-1:0]   w_miss_base;

   assign w_nodes     = {1'b0, number_of_nodes};
   assign w_to        = {1'b0, ec_to_node};
   assign w_hit       = row_valid_q && (row_tag_q == ec_from_node);
   assign w_ready     = ec_query && w_hit && (state_q == IDLE);
   assign w_in_range  = (w_to < w_nodes) && (w_to < c_max_nodes);
   assign w_accept    = mem_read_q && !mem_waitrequest;
   assign w_issue_d   = issue_q + CNT_W'(1);
   assign w_recv_d    = recv_q + CNT_W'(mem_readdatavalid);
   assign w_done      = (w_recv_d >= w_nodes);
   assign w_row_base  = base_address + ADDR_WIDTH'(row_tag_q) * ADDR_WIDTH'(MAX_NODES);
   assign w_miss_base = base_address + ADDR_WIDTH'(ec_from_node) * ADDR_WIDTH'(MAX_NODES);

   // Hit path is purely combinational so the engine can sweep one column per cycle.
   assign ec_ready      = w_ready;
   assign ec_edge_value = !w_ready   ? '0 :
                          w_in_range ? row_buf_q[ec_to_node[BUF_AW-1:0]] : c_no_edge;
   assign mem_read      = mem_read_q;
   assign mem_address   = mem_address_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         row_valid_q   <= 1'b0;
         flush_pend_q  <= 1'b0;
         row_tag_q     <= '0;
         issue_q       <= '0;
         recv_q        <= '0;
         mem_read_q    <= 1'b0;
         mem_address_q <= '0;
         for (int i = 0; i < MAX_NODES; i++) begin
            row_buf_q[i] <= c_no_edge;
         end
      end else begin
         case (state_q)
            IDLE: begin
               mem_read_q <= 1'b0;
               if (flush) begin
                  row_valid_q <= 1'b0;
               end else if (ec_query && !w_hit) begin
                  row_tag_q     <= ec_from_node;
                  row_valid_q   <= 1'b0;
                  flush_pend_q  <= 1'b0;
                  issue_q       <= '0;
                  recv_q        <= '0;
                  mem_read_q    <= (number_of_nodes != '0);
                  mem_address_q <= w_miss_base;
                  state_q       <= FETCH;
               end
            end
            FETCH: begin
               if (flush) begin
                  flush_pend_q <= 1'b1;
               end
               if (mem_readdatavalid && (recv_q < c_max_nodes)) begin
                  row_buf_q[recv_q[BUF_AW-1:0]] <= mem_readdata;
               end
               recv_q <= w_recv_d;
               // Request and address only advance once the slave accepts.
               if (w_accept) begin
                  issue_q       <= w_issue_d;
                  mem_read_q    <= (w_issue_d < w_nodes);
                  mem_address_q <= w_row_base + ADDR_WIDTH'(w_issue_d);
               end
               if (w_done) begin
                  row_valid_q  <= !(flush_pend_q || flush);
                  flush_pend_q <= 1'b0;
                  mem_read_q   <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_edge_cache.sv
// Testbench for edge_cache: randomized memory slave plus directed query sequence.
`timescale 1ns/1ps
`default_nettype none

module tb_edge_cache;
   localparam int MAXN = 16;
   localparam int IW   = 8;
   localparam int VW   = 16;
   localparam int AW   = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          flush = 1'b0;
   logic [AW-1:0] base_address = '0;
   logic [IW-1:0] number_of_nodes = '0;
   logic          ec_query = 1'b0;
   logic [IW-1:0] ec_from_node = '0;
   logic [IW-1:0] ec_to_node = '0;
   logic          ec_ready;
   logic [VW-1:0] ec_edge_value;
   logic          mem_read;
   logic [AW-1:0] mem_address;
   logic          mem_waitrequest = 1'b0;
   logic [VW-1:0] mem_readdata = '0;
   logic          mem_readdatavalid = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic stall_en = 1'b0;
   logic rand_lat = 1'b0;
   int fix_lat = 2;
   int last_due = 0;

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } req_t;
   req_t          pend[$];
   logic [AW-1:0] addr_log[$];
   int            acc_cyc[$];

   edge_cache #(
      .MAX_NODES(MAXN), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW), .ADDR_WIDTH(AW)
   ) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .base_address(base_address), .number_of_nodes(number_of_nodes),
      .ec_query(ec_query), .ec_from_node(ec_from_node), .ec_to_node(ec_to_node),
      .ec_ready(ec_ready), .ec_edge_value(ec_edge_value),
      .mem_read(mem_read), .mem_address(mem_address),
      .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
      .mem_readdatavalid(mem_readdatavalid)
   );

   initial forever #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [VW-1:0] mem_word(input logic [AW-1:0] a);
      return (a[15:0] * 16'd29) ^ a[31:16] ^ 16'h3a5c;
   endfunction

   function automatic logic [AW-1:0] row_addr(input logic [AW-1:0] base, input int row, input int k);
      return base + AW'(row * MAXN + k);
   endfunction

   // Memory slave: random stalls, in-order responses after 1..5 (or fixed) cycles.
   initial begin
      forever begin
         @(negedge clock);
         if (!reset) begin
            pend.delete();
            last_due = 0;
            mem_readdatavalid = 1'b0;
            mem_waitrequest = 1'b0;
         end else begin
            mem_waitrequest = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
               mem_readdatavalid = 1'b1;
               mem_readdata = mem_word(pend[0].addr);
               void'(pend.pop_front());
            end else begin
               mem_readdatavalid = 1'b0;
            end
            if (mem_read && !mem_waitrequest) begin
               req_t r;
               int lat;
               lat = rand_lat ? int'($urandom_range(1, 5)) : fix_lat;
               r.addr = mem_address;
               r.due = cyc + lat;
               if (r.due <= last_due) r.due = last_due + 1;
               last_due = r.due;
               pend.push_back(r);
               addr_log.push_back(mem_address);
               acc_cyc.push_back(cyc);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input int budget, output int n);
      n = 0;
      while (!ec_ready && n < budget) begin
         @(negedge clock); #1;
         n++;
      end
      check("ready_within_budget", ec_ready, 1);
   endtask

   task automatic clear_logs();
      addr_log.delete();
      acc_cyc.delete();
   endtask

   task automatic flush_idle();
      @(negedge clock);
      ec_query = 1'b0;
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
   endtask

   task automatic check_addrs(input logic [AW-1:0] base, input int row, input int nodes,
                              input int off, input string tag);
      for (int k = 0; k < nodes; k++) begin
         logic [AW-1:0] obs;
         obs = (off + k < addr_log.size()) ? addr_log[off + k] : 32'hdead_beef;
         check(tag, obs, row_addr(base, row, k));
      end
   endtask

   task automatic sweep(input logic [AW-1:0] base, input int row, input int nodes, input string tag);
      for (int to = 0; to <= nodes + 1; to++) begin
         logic [VW-1:0] exp;
         @(negedge clock);
         ec_to_node = IW'(to);
         #1;
         exp = (to < nodes) ? mem_word(row_addr(base, row, to)) : '1;
         check({tag, "_ready"}, ec_ready, 1);
         check({tag, "_value"}, ec_edge_value, exp);
      end
   endtask

   initial begin
      int q;
      int n;
      int k;
      int row;
      int nodes;
      logic [AW-1:0] base;

      #1;
      check("rst_ready", ec_ready, 0);
      check("rst_value", ec_edge_value, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_address", mem_address, 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Basic miss: 4 nodes, base 0x100, row 2, latency 2.
      number_of_nodes = 8'd4;
      base_address = 32'h100;
      clear_logs();
      @(negedge clock);
      q = cyc;
      ec_query = 1'b1;
      ec_from_node = 8'd2;
      ec_to_node = 8'd0;
      #1;
      check("miss_ready_low", ec_ready, 0);
      wait_ready(50, n);
      check("miss_latency", n, 7);
      check("miss_nreads", addr_log.size(), 4);
      check_addrs(32'h100, 2, 4, 0, "miss_addr");
      check("first_read_cycle", (acc_cyc.size() > 0) ? acc_cyc[0] - q : -1, 1);
      check("back_to_back", (acc_cyc.size() == 4) ? acc_cyc[3] - acc_cyc[0] : -1, 3);
      sweep(32'h100, 2, 4, "row2");

      // Re-query of the cached row hits immediately without memory traffic.
      @(negedge clock);
      ec_query = 1'b0;
      #1;
      check("noquery_ready", ec_ready, 0);
      check("noquery_value", ec_edge_value, 0);
      @(negedge clock);
      ec_query = 1'b1;
      ec_to_node = 8'd3;
      #1;
      check("hit_ready", ec_ready, 1);
      check("hit_value", ec_edge_value, mem_word(32'h123));
      repeat (3) @(negedge clock);
      #1;
      check("hit_no_reads", addr_log.size(), 4);

      // Moving to an uncached row drops ready in the same cycle.
      @(negedge clock);
      ec_from_node = 8'd7;
      #1;
      check("from_change_ready", ec_ready, 0);
      @(negedge clock);
      ec_query = 1'b0;
      repeat (20) @(negedge clock);

      // Flush during a fetch of row 1: no ready after that fetch, refetch follows.
      flush_idle();
      clear_logs();
      fix_lat = 3;
      @(negedge clock);
      ec_query = 1'b1;
      ec_from_node = 8'd1;
      ec_to_node = 8'd0;
      @(negedge clock);
      @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      wait_ready(100, n);
      check("flush_fetch_nreads", addr_log.size(), 8);
      check_addrs(32'h100, 1, 4, 0, "flush_addr_a");
      check_addrs(32'h100, 1, 4, 4, "flush_addr_b");
      sweep(32'h100, 1, 4, "row1");

      // Flush while idle and hitting: ready holds this cycle, drops next, then refetch.
      @(negedge clock);
      flush = 1'b1;
      #1;
      check("idle_flush_same_cycle", ec_ready, 1);
      @(negedge clock);
      flush = 1'b0;
      #1;
      check("idle_flush_next_cycle", ec_ready, 0);
      wait_ready(100, n);
      check("idle_flush_nreads", addr_log.size(), 12);

      // Row 1 -> 3 mid-fetch: row 1 completes, row 3 follows.
      flush_idle();
      clear_logs();
      fix_lat = 2;
      @(negedge clock);
      ec_query = 1'b1;
      ec_from_node = 8'd1;
      ec_to_node = 8'd0;
      @(negedge clock);
      @(negedge clock);
      ec_from_node = 8'd3;
      wait_ready(100, n);
      check("switch_nreads", addr_log.size(), 8);
      check_addrs(32'h100, 1, 4, 0, "switch_addr_row1");
      check_addrs(32'h100, 3, 4, 4, "switch_addr_row3");
      sweep(32'h100, 3, 4, "row3");

      // Zero nodes: valid with no reads, every lookup is no-edge.
      flush_idle();
      clear_logs();
      number_of_nodes = 8'd0;
      @(negedge clock);
      ec_query = 1'b1;
      ec_from_node = 8'd9;
      ec_to_node = 8'd0;
      #1;
      wait_ready(10, n);
      check("zero_latency", n, 2);
      check("zero_nreads", addr_log.size(), 0);
      check("zero_value0", ec_edge_value, 16'hffff);
      @(negedge clock);
      ec_to_node = 8'd3;
      #1;
      check("zero_value3", ec_edge_value, 16'hffff);

      // Random rows, sizes, bases, stalls and latencies.
      for (int it = 0; it < 6; it++) begin
         flush_idle();
         clear_logs();
         nodes = (it == 0) ? 4 : int'($urandom_range(1, MAXN));
         row = int'($urandom_range(0, MAXN - 1));
         base = $urandom & 32'h00ff_fff0;
         number_of_nodes = IW'(nodes);
         base_address = base;
         stall_en = 1'b1;
         rand_lat = 1'b1;
         @(negedge clock);
         ec_query = 1'b1;
         ec_from_node = IW'(row);
         ec_to_node = 8'd0;
         wait_ready(800, n);
         check("rand_nreads", addr_log.size(), nodes);
         check_addrs(base, row, nodes, 0, "rand_addr");
         sweep(base, row, nodes, "rand");
      end
      stall_en = 1'b0;
      rand_lat = 1'b0;

      // Asynchronous reset in the middle of a fetch.
      flush_idle();
      clear_logs();
      number_of_nodes = 8'd4;
      base_address = 32'h100;
      @(negedge clock);
      ec_query = 1'b1;
      ec_from_node = 8'd2;
      ec_to_node = 8'd0;
      k = 0;
      while (addr_log.size() < 3 && k < 20) begin
         @(negedge clock); #1;
         k++;
      end
      check("reach_issue3", addr_log.size(), 3);
      @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_ready", ec_ready, 0);
      check("async_rst_value", ec_edge_value, 0);
      check("async_rst_mem_read", mem_read, 0);
      check("async_rst_mem_address", mem_address, 0);
      @(negedge clock);
      @(negedge clock);
      clear_logs();
      reset = 1'b1;
      #1;
      wait_ready(50, n);
      check("post_rst_latency", n, 7);
      check("post_rst_nreads", addr_log.size(), 4);
      check_addrs(32'h100, 2, 4, 0, "post_rst_addr");
      sweep(32'h100, 2, 4, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/edge_cache.md
# edge_cache

Single-row adjacency-matrix cache that answers the Dijkstra engine's edge queries (`ec_*` handshake) from a local row buffer, fetching rows from external graph memory over a pipelined read master on a miss. It sits directly upstream of the Dijkstra engine. The engine holds `ec_from_node` constant for a whole visit and sweeps `ec_to_node` from 0 upward, so one row fetch per visited node serves every neighbour lookup at zero latency.

## Interface
Parameters:
- `MAX_NODES`, `DEFAULT_MAX_NODES`: row buffer depth and matrix row stride, in words.
- `INDEX_WIDTH`, `DEFAULT_INDEX_WIDTH`: node index width.
- `VALUE_WIDTH`, `DEFAULT_VALUE_WIDTH`: edge weight width; also the memory word width.
- `ADDR_WIDTH`, 32: memory word-address width.

Ports:
- `clock`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `flush`  in  1  sync pulse; invalidates the cached row (graph rewritten).
- `base_address`  in  ADDR_WIDTH  word address of matrix row 0.
- `number_of_nodes`  in  INDEX_WIDTH  valid nodes per row; static while `ec_query` is high.
- `ec_query`  in  1  level; engine requests edges from `ec_from_node`.
- `ec_from_node`  in  INDEX_WIDTH  row selector.
- `ec_to_node`  in  INDEX_WIDTH  column selector.
- `ec_ready`  out  1  `ec_edge_value` is valid for the current from/to pair.
- `ec_edge_value`  out  VALUE_WIDTH  edge weight.
- `mem_read`  out  1  read request.
- `mem_address`  out  ADDR_WIDTH  word address.
- `mem_waitrequest`  in  1  request stalled; hold `mem_read` and `mem_address`.
- `mem_readdata`  in  VALUE_WIDTH  returned word.
- `mem_readdatavalid`  in  1  `mem_readdata` valid; in-order, any number outstanding.

## Operation
- Storage:
  - `row_buf[MAX_NODES]` of VALUE_WIDTH.
  - `row_tag` (INDEX_WIDTH).
  - `row_valid` flag.
  - `issue_cnt` and `recv_cnt`, each INDEX_WIDTH+1 bits.
- Hit when `row_valid && row_tag == ec_from_node`.
- `ec_ready = ec_query && hit && state == IDLE`. Combinational; it drops in the same cycle `ec_from_node` moves to a non-cached row.
- `ec_edge_value`:
  - `row_buf[ec_to_node]` when `ec_ready` and `ec_to_node < number_of_nodes`.
  - All-ones (no edge) when `ec_ready` and `ec_to_node >= number_of_nodes`.
  - 0 otherwise.
- State `IDLE`: if `ec_query && !hit`:
  - latch `row_tag <= ec_from_node`, clear `row_valid`;
  - zero both counters;
  - go to `FETCH`.
- State `FETCH`:
  - `mem_read` is high while `issue_cnt < number_of_nodes`.
  - `mem_address = base_address + row_tag*MAX_NODES + issue_cnt`, computed at ADDR_WIDTH, wrap-around ignored.
  - `issue_cnt` increments on each cycle with `mem_read && !mem_waitrequest`.
  - On each `mem_readdatavalid`: `row_buf[recv_cnt] <= mem_readdata`, `recv_cnt++`.
  - When `recv_cnt` reaches `number_of_nodes` (including the current beat): set `row_valid` and go to `IDLE`.
- `number_of_nodes == 0`: the row becomes valid with no memory reads (FETCH lasts one cycle). All lookups then return all-ones.
- `ec_from_node` changes or `ec_query` drops mid-fetch:
  - the fetch still completes, since outstanding reads cannot be cancelled;
  - the row is tagged with the latched `row_tag`;
  - IDLE then re-evaluates and refetches if needed.
- `flush`:
  - in IDLE: clears `row_valid` next edge;
  - in FETCH: sets a pending bit; `row_valid` stays 0 when the fetch ends;
  - simultaneous `flush` and miss in IDLE: flush wins for that cycle, fetch starts the next cycle.
- `mem_readdatavalid` while in IDLE is ignored.
- `reset` low, at any time, asynchronously forces:
  - state IDLE;
  - `row_valid` 0, pending flush 0, counters 0;
  - `row_buf` all-ones;
  - `mem_read` 0, `mem_address` 0;
  - outputs low.
- Memory responses still in flight after reset are the system's responsibility; the whole pathfinder is reset together.

## Timing
- Reset values: `ec_ready` 0, `ec_edge_value` 0, `mem_read` 0, `mem_address` 0.
- Hit: zero-cycle latency. `ec_ready` and `ec_edge_value` follow `ec_to_node` combinationally, so the engine can advance `ec_to_node` every cycle.
- Miss, assuming no waitrequest and read latency L:
  - `mem_read` first high 1 cycle after the miss is seen;
  - `ec_ready` high `number_of_nodes + L + 1` cycles after the miss.
- `mem_read` and `mem_address` are registered and held stable while `mem_waitrequest` is high.
- At most `number_of_nodes` reads are issued per fetch.

## Test plan
- Reset 0 mid-FETCH (`issue_cnt` = 3) -> outputs 0 immediately; after release, a query for row 2 refetches from word 0.
- `number_of_nodes=4`, base 0x100, query from 2, no stalls, L=2:
  - reads 0x100+2*MAX_NODES .. +3 issued back-to-back;
  - `ec_ready` rises 7 cycles after the query;
  - sweeping to 0..3 returns the memory words.
- Same row queried again -> `ec_ready` in the same cycle with no `mem_read`.
- `ec_to_node=5`, `number_of_nodes=4` -> value all-ones.
- Random `mem_waitrequest` (50%) and L=1..5 -> correct row contents; exactly 4 reads issued.
- `flush` during a fetch of row 1 -> the fetch completes and `ec_ready` stays 0; the next query refetches row 1.
- `ec_from_node` 1->3 mid-fetch -> row 1 completes, row 3 fetch follows, `ec_ready` only for 3.
